// File: rtl/imap_rd_ctrl_pkg.sv
// Shared constants and state encoding for the input feature map read sequencer.
package imap_rd_ctrl_pkg;

    localparam int unsigned BLOCK_SIZE = 56 * 56;
    localparam int unsigned GRP_BIT    = 12;
    localparam int unsigned KERNEL     = 3;
    localparam int unsigned PIX_W      = $clog2(BLOCK_SIZE);
    localparam int unsigned DIM_W      = 6;
    localparam int unsigned KER_W      = $clog2(KERNEL);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/imap_tap_cnt.sv
// Nested oh/ow/grp/ky/kx tap counters plus tap position, bounds and pixel index.
module imap_tap_cnt
    import imap_rd_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIM_W-1:0] h,
    input  logic [DIM_W-1:0] w,
    input  logic             two_grp,
    output logic             grp,
    output logic             in_range,
    output logic [PIX_W-1:0] pix,
    output logic             pix_last,
    output logic             last
);

    localparam int unsigned RW = DIM_W + 1;

    logic [DIM_W-1:0] oh_q, oh_d, ow_q, ow_d;
    logic             grp_q, grp_d;
    logic [KER_W-1:0] ky_q, ky_d, kx_q, kx_d;
    logic [RW-1:0]    row, col;
    logic             kx_wrap, ky_wrap, grp_wrap, ow_wrap, oh_wrap;

    assign kx_wrap  = (kx_q == KER_W'(KERNEL - 1));
    assign ky_wrap  = (ky_q == KER_W'(KERNEL - 1));
    assign grp_wrap = (grp_q == two_grp);
    assign ow_wrap  = (ow_q == w - DIM_W'(1));
    assign oh_wrap  = (oh_q == h - DIM_W'(1));

    assign pix_last = kx_wrap && ky_wrap && grp_wrap;
    assign last     = pix_last && ow_wrap && oh_wrap;
    assign grp      = grp_q;

    always_comb begin
        oh_d  = oh_q;
        ow_d  = ow_q;
        grp_d = grp_q;
        ky_d  = ky_q;
        kx_d  = kx_q;
        if (clr) begin
            oh_d  = '0;
            ow_d  = '0;
            grp_d = 1'b0;
            ky_d  = '0;
            kx_d  = '0;
        end else if (en) begin
            kx_d = kx_wrap ? '0 : kx_q + KER_W'(1);
            if (kx_wrap) begin
                ky_d = ky_wrap ? '0 : ky_q + KER_W'(1);
                if (ky_wrap) begin
                    grp_d = grp_wrap ? 1'b0 : 1'b1;
                    if (grp_wrap) begin
                        ow_d = ow_wrap ? '0 : ow_q + DIM_W'(1);
                        if (ow_wrap) begin
                            oh_d = oh_wrap ? '0 : oh_q + DIM_W'(1);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oh_q  <= '0;
            ow_q  <= '0;
            grp_q <= 1'b0;
            ky_q  <= '0;
            kx_q  <= '0;
        end else begin
            oh_q  <= oh_d;
            ow_q  <= ow_d;
            grp_q <= grp_d;
            ky_q  <= ky_d;
            kx_q  <= kx_d;
        end
    end

    // Padding 1: a tap sits one row/col above-left of the output pixel; -1 shows up as the sign bit.
    assign row = {1'b0, oh_q} + RW'(ky_q) - RW'(1);
    assign col = {1'b0, ow_q} + RW'(kx_q) - RW'(1);

    assign in_range = !row[RW-1] && (row[DIM_W-1:0] < h) &&
                      !col[RW-1] && (col[DIM_W-1:0] < w);

    assign pix = PIX_W'(row[DIM_W-1:0]) * PIX_W'(w) + PIX_W'(col[DIM_W-1:0]);

endmodule

// File: rtl/imap_rd_ctrl.sv
// Read-side sequencer: walks 3x3 taps per output pixel, drives buffer reads, tags returned words.
module imap_rd_ctrl
    import imap_rd_ctrl_pkg::*;
#(
    parameter int unsigned MAX_DIM = 56,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic              cfg_two_grp,
    input  logic              imap_wen,
    input  logic              stall,
    output logic [ADDR_W-1:0] imap_raddr,
    output logic              imap_ren,
    output logic              win_valid,
    output logic              win_pad,
    output logic              win_last,
    output logic              busy,
    output logic              done
);

    state_e           state_q, state_d;
    logic [DIM_W-1:0] h_q, h_d, w_q, w_d;
    logic             two_grp_q;
    logic             win_valid_q, win_pad_q, win_last_q;
    logic             accept, zero_dim, issue;
    logic             grp, in_range, pix_last, last;
    logic [PIX_W-1:0] pix;

    assign accept   = (state_q == StIdle) && start;
    assign zero_dim = (cfg_h == '0) || (cfg_w == '0);
    // Buffer writes own the shared SRAM port, so they pre-empt issue in the same cycle.
    assign issue    = (state_q == StRun) && !imap_wen && !stall;

    // Clamp keeps row*W+col inside the buffer for out-of-range configurations.
    assign h_d = (cfg_h > DIM_W'(MAX_DIM)) ? DIM_W'(MAX_DIM) : cfg_h;
    assign w_d = (cfg_w > DIM_W'(MAX_DIM)) ? DIM_W'(MAX_DIM) : cfg_w;

    imap_tap_cnt u_tap_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .en       (issue),
        .h        (h_q),
        .w        (w_q),
        .two_grp  (two_grp_q),
        .grp      (grp),
        .in_range (in_range),
        .pix      (pix),
        .pix_last (pix_last),
        .last     (last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = zero_dim ? StDone : StRun;
            StRun:   if (issue && last) state_d = StDrain;
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        imap_ren   = issue && in_range;
        imap_raddr = '0;
        if (imap_ren) begin
            imap_raddr[GRP_BIT]     = grp;
            imap_raddr[PIX_W-1:0]   = pix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            h_q         <= '0;
            w_q         <= '0;
            two_grp_q   <= 1'b0;
            win_valid_q <= 1'b0;
            win_pad_q   <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_valid_q <= issue;
            win_pad_q   <= issue && !in_range;
            win_last_q  <= issue && pix_last;
            if (accept) begin
                h_q       <= h_d;
                w_q       <= w_d;
                two_grp_q <= cfg_two_grp;
            end
        end
    end

    assign win_valid = win_valid_q;
    assign win_pad   = win_pad_q;
    assign win_last  = win_last_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_imap_rd_ctrl.sv
// Scoreboard bench for imap_rd_ctrl: a tap model fills a queue at start, window outputs drain it.
module tb_imap_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  cfg_h, cfg_w;
    logic        cfg_two_grp;
    logic        imap_wen, stall;
    logic [31:0] imap_raddr;
    logic        imap_ren, win_valid, win_pad, win_last, busy, done;

    imap_rd_ctrl #(
        .MAX_DIM (56),
        .ADDR_W  (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_h       (cfg_h),
        .cfg_w       (cfg_w),
        .cfg_two_grp (cfg_two_grp),
        .imap_wen    (imap_wen),
        .stall       (stall),
        .imap_raddr  (imap_raddr),
        .imap_ren    (imap_ren),
        .win_valid   (win_valid),
        .win_pad     (win_pad),
        .win_last    (win_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic        pad;
        logic        last;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0, done_cyc = -1;
    int valid_cnt = 0, ren_cnt = 0;
    int busy_start = -1, busy_last = -1;
    logic        busy_prev = 1'b0;
    logic        prev_ren = 1'b0;
    logic [31:0] prev_addr = '0;
    int t_start;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy && !busy_prev) busy_start = cyc;
        if (busy) busy_last = cyc;
        busy_prev = busy;
        if (imap_ren) ren_cnt++;
        if (imap_wen || stall) check("ren_blocked", {31'b0, imap_ren}, 32'd0);
        if (!imap_ren) check("raddr_idle", imap_raddr, 32'd0);
        if (win_valid) begin
            valid_cnt++;
            check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("tap_ren", {31'b0, prev_ren}, {31'b0, e.ren});
                check("tap_addr", prev_addr, e.addr);
                check("win_pad", {31'b0, win_pad}, {31'b0, e.pad});
                check("win_last", {31'b0, win_last}, {31'b0, e.last});
            end
        end
        prev_ren  = imap_ren;
        prev_addr = imap_raddr;
    end

    task automatic push_model(input int h, input int w, input int g);
        exp_t e;
        for (int oh = 0; oh < h; oh++)
            for (int ow = 0; ow < w; ow++)
                for (int gr = 0; gr < g; gr++)
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++) begin
                            int row, col;
                            row    = oh + ky - 1;
                            col    = ow + kx - 1;
                            e.ren  = (row >= 0 && row < h && col >= 0 && col < w);
                            e.addr = e.ren ? 32'(gr * 4096 + row * w + col) : 32'd0;
                            e.pad  = !e.ren;
                            e.last = (ky == 2 && kx == 2 && gr == g - 1);
                            sb.push_back(e);
                        end
    endtask

    task automatic do_start(input int h, input int w, input logic two);
        @(posedge clk); #1;
        cfg_h       = 6'(h);
        cfg_w       = 6'(w);
        cfg_two_grp = two;
        start       = 1'b1;
        t_start     = cyc;
        @(posedge clk); #1;
        start       = 1'b0;
        // Scramble config mid-run: it must already be latched.
        cfg_h       = 6'd7;
        cfg_w       = 6'd2;
        cfg_two_grp = ~two;
    endtask

    // mode 0: free-running, 1: imap_wen held 5 cycles, 2: stall every other cycle
    task automatic do_run(input int h, input int w, input logic two, input int mode);
        int n, d0, v0, exp_done;
        n  = h * w * (two ? 2 : 1) * 9;
        d0 = done_cnt;
        v0 = valid_cnt;
        push_model(h, w, two ? 2 : 1);
        do_start(h, w, two);
        for (int i = 0; i < n + 300 && done_cnt == d0; i++) begin
            imap_wen = (mode == 1) && (cyc - t_start >= 20) && (cyc - t_start < 25);
            stall    = (mode == 2) && cyc[0];
            @(posedge clk); #1;
        end
        imap_wen = 1'b0;
        stall    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_done = (n == 0) ? 1 : n + 2 + ((mode == 1) ? 5 : 0);
        check("done_seen", 32'(done_cnt - d0), 32'd1);
        if (mode != 2) begin
            check("done_time", 32'(done_cyc - t_start), 32'(exp_done));
            check("busy_first", 32'(busy_start - t_start), 32'd1);
            check("busy_last", 32'(busy_last - t_start), 32'(exp_done));
        end
        check("valid_cnt", 32'(valid_cnt - v0), 32'(n));
        check("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        int d0, r0, v0, b0;
        rst = 1'b1; start = 1'b0; cfg_h = '0; cfg_w = '0; cfg_two_grp = 1'b0;
        imap_wen = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_ren", {31'b0, imap_ren}, 32'd0);
        check("rst_raddr", imap_raddr, 32'd0);
        check("rst_valid", {31'b0, win_valid}, 32'd0);
        check("rst_pad_last", {30'b0, win_pad, win_last}, 32'd0);
        rst = 1'b0;

        do_run(3, 3, 1'b0, 0);
        do_run(56, 56, 1'b1, 0);
        do_run(3, 3, 1'b0, 1);
        do_run(3, 3, 1'b0, 2);

        // Reset 10 cycles into a run: immediate abort, no done, then a clean restart.
        d0 = done_cnt;
        push_model(3, 3, 1);
        do_start(3, 3, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_ren", {31'b0, imap_ren}, 32'd0);
        check("abort_valid", {31'b0, win_valid}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        sb.delete();
        repeat (100) @(posedge clk);
        #1 check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        do_run(3, 3, 1'b0, 0);

        // Zero height: done at T+1, no reads; a start landing in the done cycle is dropped.
        d0 = done_cnt; r0 = ren_cnt; v0 = valid_cnt; b0 = busy_start;
        do_start(0, 5, 1'b0);
        cfg_h = 6'd3; cfg_w = 6'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (120) @(posedge clk);
        #1;
        check("zero_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("zero_done_time", 32'(done_cyc - t_start), 32'd1);
        check("zero_busy_first", 32'(busy_start - t_start), 32'd1);
        check("zero_busy_last", 32'(busy_last - t_start), 32'd1);
        check("zero_no_ren", 32'(ren_cnt - r0), 32'd0);
        check("zero_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("zero_busy_moved", {31'b0, busy_start != b0}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imap_rd_ctrl.md
# imap_rd_ctrl

Read-side sequencer for the input feature map buffer. On a start pulse it walks every output pixel of the configured tile, issuing the nine 3x3 tap reads per channel group, with padding 1 and stride 1. It drives the buffer's read address/enable and yields to buffer writes, which share the SRAM ports. It also tags each returned word with valid, pad and last-tap flags, aligned to the buffer's 1-cycle read latency, for the MAC array.

## Interface
Parameters:
- MAX_DIM, 56, largest tile height/width supported
- ADDR_W, 32, width of the buffer read address

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse; ignored while busy
- cfg_h  in  6  tile height H, 0..MAX_DIM; sampled at start
- cfg_w  in  6  tile width W, 0..MAX_DIM; sampled at start
- cfg_two_grp  in  1  1 = two channel groups (buffer addr bit 12 = 0 then 1); 0 = group 0 only
- imap_wen  in  1  buffer write in progress this cycle; blocks read issue
- stall  in  1  MAC array back-pressure; blocks read issue
- imap_raddr  out  ADDR_W  buffer read address
- imap_ren  out  1  buffer read enable
- win_valid  out  1  tap result present this cycle, aligned with buffer read data
- win_pad  out  1  with win_valid: tap is padding, consumer must use zero data
- win_last  out  1  with win_valid: last tap of the current output pixel
- busy  out  1  sequence in progress
- done  out  1  single-cycle completion pulse

## Operation
- FSM states:
  - IDLE: start -> RUN, or -> DONE if cfg_h==0 or cfg_w==0.
  - RUN: on the last tap issue -> DRAIN.
  - DRAIN: one cycle, emits the final win_valid -> DONE.
  - DONE: one cycle, done=1 -> IDLE.
- Loop order, outermost first: oh 0..H-1, ow 0..W-1, grp 0..G-1, ky 0..2, kx 0..2.
  - G = 2 if cfg_two_grp, else 1.
  - Total taps = H*W*G*9.
- Advance: in RUN, a tap issues and the counters advance only when imap_wen==0 and stall==0. Otherwise all counters hold.
- Tap position: row = oh+ky-1, col = ow+kx-1, computed signed, 7 bits.
  - In range iff 0<=row<H and 0<=col<W.
- In-range tap:
  - imap_ren=1.
  - imap_raddr = {zeros, grp, pix[11:0]}, with pix = row*W+col.
  - Maximum pix is 3135, so it always fits 12 bits.
- Padding tap: imap_ren=0 and imap_raddr=0. It still consumes an issue cycle and produces win_valid with win_pad=1.
- imap_ren and imap_raddr are combinational from registered counters gated by imap_wen and stall. Write always wins the shared port in the same cycle.
- win_valid, win_pad and win_last are registered copies of (issue, pad, ky==2&&kx==2&&grp==G-1).
- cfg values are latched at start. Changes during RUN have no effect.

## Timing
- Reset: state IDLE, all counters 0, every output 0.
- Reset mid-run aborts immediately: outputs 0 next cycle, no done pulse, and in-flight data is discarded (win_valid=0).
- Start accepted in cycle T: first issue is possible at T+1.
- With no blocking, the last tap issues at T+N, where N = total taps.
- win_valid follows each issue by exactly 1 cycle.
- done is high at T+N+2. busy is high from T+1 through T+N+2 inclusive.
- Zero dimension: done at T+1, no issues, busy high only at T+1.
- Each blocked cycle (imap_wen or stall) delays all subsequent events by one cycle.
- Data already issued still returns one cycle later regardless of stall; the consumer must accept it.
- start arriving during busy (including the DONE cycle) is dropped.

## Structure
- Shared package holds:
  - BLOCK_SIZE (56*56)
  - the state encoding (IDLE/RUN/DRAIN/DONE)
  - GRP_BIT (12)
  - KERNEL (3)
- One natural sub-module: imap_tap_cnt. It holds the nested oh/ow/grp/ky/kx counters with enable, wrap and last flag, and the row/col/in-range computation. The top keeps the FSM, the gating and the output pipeline registers.

## Test plan
- H=W=3, G=1, no blocking:
  - 81 issues.
  - Pixel (0,0) gives pad,pad,pad,pad, addr 0, addr 1, pad, addr 3, addr 4.
  - win_last on every 9th valid.
  - done at T+83.
- H=W=56, G=2:
  - Group 1 taps have bit 12 set.
  - Last pixel center tap addr = 4096+3135.
  - Bottom/right taps are pads.
  - 56448 valids.
- imap_wen held 5 cycles mid-RUN:
  - imap_ren=0 in those cycles.
  - The address sequence resumes unchanged.
  - done is delayed by 5.
- stall toggled every other cycle:
  - No tap is lost or duplicated.
  - The win_valid count equals 81 for the 3x3 case.
- rst asserted 10 cycles into a run:
  - All outputs 0 next cycle, no done.
  - A fresh start then runs the full sequence from pixel 0.
- cfg_h=0:
  - done at T+1, imap_ren never asserted.
  - A second start during the done cycle is ignored.
